issue_scoreboard: RTL and testbench

- Issue scheduler between the decode stage and the execute stage of the 5-stage MIPS32 pipeline.
- Tracks in-flight register writes with a per-register scoreboard.
- Stalls decode on read-after-write hazards that forwarding cannot cover, such as load-use.
- Drives per-operand forward/regfile select, so the pipeline issues at most one instruction per cycle in order.

---
 rtl/issue_scoreboard.sv | 79 +++++++
 tb/tb_issue_scoreboard.sv | 127 ++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: decode-to-execute RAW scoreboard with stall/forward select; ISSUE_SCOREBOARD_STATS_EN adds stall/issue counters
module issue_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    output logic                dec_ready,
    input  logic [4:0]          dec_rs,
    input  logic [4:0]          dec_rt,
    input  logic                dec_uses_rs,
    input  logic                dec_uses_rt,
    input  logic                dec_wr_en,
    input  logic [4:0]          dec_wr_reg,
    input  logic                dec_is_load,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [4:0]          wb_reg,
    output logic                issue,
    output logic                stall,
    output logic                fwd_a,
    output logic                fwd_b,
    output logic [NUM_REGS-1:0] busy_mask
`ifdef ISSUE_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         issue_count
`endif
);
    logic [NUM_REGS-1:0] pend;
    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic                use_a, use_b, haz_a, haz_b, hazard;
    // count is first observed the cycle after issue, so it is loaded one short of the latency
    localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT - 1);
    always_comb begin
        use_a     = !rst && dec_uses_rs && dec_rs != 5'd0;
        use_b     = !rst && dec_uses_rt && dec_rt != 5'd0;
        haz_a     = use_a && cnt[dec_rs] != '0;
        haz_b     = use_b && cnt[dec_rt] != '0;
        hazard    = haz_a || haz_b;
        dec_ready = !hazard;
        stall     = dec_valid && hazard && !flush;
        issue     = dec_valid && dec_ready && !flush;
        fwd_a     = use_a && pend[dec_rs] && cnt[dec_rs] == '0;
        fwd_b     = use_b && pend[dec_rt] && cnt[dec_rt] == '0;
        busy_mask = rst ? '0 : {pend[NUM_REGS-1:1], 1'b0};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) cnt[i] <= cnt[i] != '0 ? cnt[i] - 1'b1 : '0;
            if (wb_en && wb_reg != 5'd0) begin
                pend[wb_reg] <= 1'b0;
                cnt[wb_reg]  <= '0;
            end
            if (issue && dec_wr_en && dec_wr_reg != 5'd0) begin
                pend[dec_wr_reg] <= 1'b1;
                cnt[dec_wr_reg]  <= dec_is_load ? LOAD_CNT : ALU_CNT;
            end
        end
    end
`ifdef ISSUE_SCOREBOARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            issue_count  <= '0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, stall};
            issue_count  <= issue_count + {31'd0, issue};
        end
    end
`endif
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: vector table through a scoreboard queue, plus stats sequence when enabled
module tb_issue_scoreboard;
    logic        clk = 1'b0, rst, dec_valid, dec_ready, dec_uses_rs, dec_uses_rt;
    logic        dec_wr_en, dec_is_load, flush, wb_en, issue, stall, fwd_a, fwd_b;
    logic [4:0]  dec_rs, dec_rt, dec_wr_reg, wb_reg;
    logic [31:0] busy_mask;
`ifdef ISSUE_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles, issue_count;
`endif
    always #5 clk = ~clk;
    issue_scoreboard dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
        .dec_wr_en(dec_wr_en), .dec_wr_reg(dec_wr_reg), .dec_is_load(dec_is_load), .flush(flush),
        .wb_en(wb_en), .wb_reg(wb_reg), .issue(issue), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .busy_mask(busy_mask)
`ifdef ISSUE_SCOREBOARD_STATS_EN
        , .stall_cycles(stall_cycles), .issue_count(issue_count)
`endif
    );
    typedef struct {
        logic        r, v, ur, ut, we, ld, fl, wbe;
        logic [4:0]  rs, rt, wr, wbr;
        logic        rdy, iss, stl, fa, fb;
        logic [31:0] busy;
    } vec_t;
    vec_t vecs[$];
    vec_t expq[$];
    int tests = 0, fails = 0;
    function automatic vec_t mk(input logic r, v, input logic [4:0] rs, rt, input logic ur, ut, we,
                                input logic [4:0] wr, input logic ld, fl, wbe, input logic [4:0] wbr,
                                input logic rdy, iss, stl, fa, fb, input logic [31:0] busy);
        vec_t x;
        x.r = r; x.v = v; x.rs = rs; x.rt = rt; x.ur = ur; x.ut = ut; x.we = we; x.wr = wr;
        x.ld = ld; x.fl = fl; x.wbe = wbe; x.wbr = wbr;
        x.rdy = rdy; x.iss = iss; x.stl = stl; x.fa = fa; x.fb = fb; x.busy = busy;
        return x;
    endfunction
    task automatic drive(input vec_t x);
        rst = x.r; dec_valid = x.v; dec_rs = x.rs; dec_rt = x.rt; dec_uses_rs = x.ur;
        dec_uses_rt = x.ut; dec_wr_en = x.we; dec_wr_reg = x.wr; dec_is_load = x.ld;
        flush = x.fl; wb_en = x.wbe; wb_reg = x.wbr;
    endtask
    task automatic step(input vec_t x);
        @(posedge clk);
        #1 drive(x);
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask
    initial begin
        vec_t e;
        drive(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // reset held two cycles, then a clean issue
        vecs.push_back(mk(1,1,5,6,1,1,0,0,0,0,0,0, 1,1,0,0,0,32'h0));
        vecs.push_back(mk(1,1,5,6,1,1,0,0,0,0,0,0, 1,1,0,0,0,32'h0));
        vecs.push_back(mk(0,1,5,6,1,1,0,0,0,0,0,0, 1,1,0,0,0,32'h0));
        // ALU back-to-back on r3
        vecs.push_back(mk(0,1,1,2,1,1,1,3,0,0,0,0, 1,1,0,0,0,32'h0));
        vecs.push_back(mk(0,1,3,0,1,0,0,0,0,0,0,0, 1,1,0,1,0,32'h8));
        // load-use on r4: one stall then forward
        vecs.push_back(mk(0,1,0,0,0,0,1,4,1,0,0,0, 1,1,0,0,0,32'h8));
        vecs.push_back(mk(0,1,0,4,0,1,0,0,0,0,0,0, 0,0,1,0,0,32'h18));
        vecs.push_back(mk(0,1,0,4,0,1,0,0,0,0,0,0, 1,1,0,0,1,32'h18));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,3, 1,0,0,0,0,32'h18));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,4, 1,0,0,0,0,32'h10));
        // writeback and load issue to r7 in the same cycle
        vecs.push_back(mk(0,1,0,0,0,0,1,7,0,0,0,0, 1,1,0,0,0,32'h0));
        vecs.push_back(mk(0,1,0,0,0,0,1,7,1,0,1,7, 1,1,0,0,0,32'h80));
        vecs.push_back(mk(0,1,7,0,1,0,0,0,0,0,0,0, 0,0,1,0,0,32'h80));
        vecs.push_back(mk(0,1,7,0,1,0,0,0,0,0,0,0, 1,1,0,1,0,32'h80));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,7, 1,0,0,0,0,32'h80));
        // r0 is never tracked
        vecs.push_back(mk(0,1,0,0,0,0,1,0,1,0,0,0, 1,1,0,0,0,32'h0));
        vecs.push_back(mk(0,1,0,0,1,1,0,0,0,0,0,0, 1,1,0,0,0,32'h0));
        // flushed load-use: no stall, no issue, its write to r10 is dropped
        vecs.push_back(mk(0,1,0,0,0,0,1,9,1,0,0,0, 1,1,0,0,0,32'h0));
        vecs.push_back(mk(0,1,9,0,1,0,1,10,0,1,0,0, 0,0,0,0,0,32'h200));
        vecs.push_back(mk(0,1,10,0,1,0,0,0,0,0,0,0, 1,1,0,0,0,32'h200));
        vecs.push_back(mk(0,1,9,10,1,1,0,0,0,0,0,0, 1,1,0,1,0,32'h200));
        // mid-operation reset
        vecs.push_back(mk(1,1,9,0,1,0,0,0,0,0,0,0, 1,1,0,0,0,32'h0));
        vecs.push_back(mk(0,1,9,0,1,0,0,0,0,0,0,0, 1,1,0,0,0,32'h0));
        // source equals destination, then an invalid decode over a hazard
        vecs.push_back(mk(0,1,12,0,1,0,1,12,1,0,0,0, 1,1,0,0,0,32'h0));
        vecs.push_back(mk(0,0,0,12,0,1,0,0,0,0,0,0, 0,0,0,0,0,32'h1000));
        vecs.push_back(mk(0,1,0,12,0,1,0,0,0,0,0,0, 1,1,0,0,1,32'h1000));
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
            expq.push_back(vecs[i]);
            #3;
            e = expq.pop_front();
            chk($sformatf("v%0d.dec_ready", i), {31'd0, dec_ready}, {31'd0, e.rdy});
            chk($sformatf("v%0d.issue", i), {31'd0, issue}, {31'd0, e.iss});
            chk($sformatf("v%0d.stall", i), {31'd0, stall}, {31'd0, e.stl});
            chk($sformatf("v%0d.fwd_a", i), {31'd0, fwd_a}, {31'd0, e.fa});
            chk($sformatf("v%0d.fwd_b", i), {31'd0, fwd_b}, {31'd0, e.fb});
            chk($sformatf("v%0d.busy_mask", i), busy_mask, e.busy);
        end
`ifdef ISSUE_SCOREBOARD_STATS_EN
        step(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        step(mk(0,1,0,0,0,0,1,20,1,0,0,0, 0,0,0,0,0,0));
        #3;
        chk("stats.issue_count_reset", issue_count, 32'd0);
        chk("stats.stall_cycles_reset", stall_cycles, 32'd0);
        step(mk(0,1,0,20,0,1,0,0,0,0,0,0, 0,0,0,0,0,0));
        step(mk(0,1,0,20,0,1,1,21,1,0,0,0, 0,0,0,0,0,0));
        step(mk(0,1,21,0,1,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        step(mk(0,1,21,0,1,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        step(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        #3;
        chk("stats.issue_count", issue_count, 32'd3);
        chk("stats.stall_cycles", stall_cycles, 32'd2);
        step(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        step(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        #3;
        chk("stats.issue_count_after_rst", issue_count, 32'd0);
        chk("stats.stall_cycles_after_rst", stall_cycles, 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
